// File: rtl/adc_decim_intf.sv
// RX ADC interface: selects one antenna lane from the packed 40 Msps ADC stream,
// decimates 2:1 (even/odd/pair-average or bypass) and buffers into a show-ahead FIFO.
module adc_decim_intf #(
    parameter int unsigned IQ_DATA_WIDTH       = 16,
    parameter int unsigned ADC_PACK_DATA_WIDTH = 64,
    parameter int unsigned FIFO_DEPTH_LOG2     = 4
) (
    input  logic                           acc_clk,
    input  logic                           acc_rstn,
    input  logic [ADC_PACK_DATA_WIDTH-1:0] adc_data,
    input  logic                           adc_valid,
    input  logic                           ant_flag,
    input  logic [1:0]                     decim_mode,
    input  logic                           phase_resync,
    output logic [2*IQ_DATA_WIDTH-1:0]     data_to_acc,
    output logic                           data_valid_to_acc,
    input  logic                           data_ready_from_acc,
    output logic [FIFO_DEPTH_LOG2:0]       fifo_level,
    output logic                           overflow_sticky,
    input  logic                           clr_overflow
);

    localparam int unsigned LANE_W = 2 * IQ_DATA_WIDTH;
    localparam int unsigned SUM_W  = IQ_DATA_WIDTH + 1;
    localparam int unsigned DEPTH  = 1 << FIFO_DEPTH_LOG2;
    localparam int unsigned PTR_W  = FIFO_DEPTH_LOG2;
    localparam int unsigned LVL_W  = FIFO_DEPTH_LOG2 + 1;

    typedef struct packed {
        logic [IQ_DATA_WIDTH-1:0] i;
        logic [IQ_DATA_WIDTH-1:0] q;
    } iq_t;

    typedef enum logic [1:0] {
        MODE_EVEN   = 2'd0,
        MODE_ODD    = 2'd1,
        MODE_AVG    = 2'd2,
        MODE_BYPASS = 2'd3
    } mode_e;

    typedef enum logic {
        PH_FIRST  = 1'b0,
        PH_SECOND = 1'b1
    } phase_e;

    // Floor of (a+b)/2 on sign-extended operands; the sum always fits SUM_W bits.
    function automatic logic [IQ_DATA_WIDTH-1:0] half_sum(
        input logic [IQ_DATA_WIDTH-1:0] a,
        input logic [IQ_DATA_WIDTH-1:0] b
    );
        logic [SUM_W-1:0] s;
        s = {a[IQ_DATA_WIDTH-1], a} + {b[IQ_DATA_WIDTH-1], b};
        return IQ_DATA_WIDTH'(s >> 1);
    endfunction

    // ------------------------------------------------------------------
    // Front end: lane select, pair phase, decimation
    // ------------------------------------------------------------------
    phase_e                 phase_q;
    phase_e                 phase_n;
    phase_e                 eff_phase_c;
    iq_t                    held_q;
    iq_t                    held_n;
    logic [1:0]             mode_q;
    mode_e                  mode_c;
    logic                   resync_c;
    iq_t                    lane_c;
    iq_t                    avg_c;
    logic                   fwd_c;
    iq_t                    fwd_data_c;
    logic                   stage_vld_q;
    iq_t                    stage_data_q;

    assign mode_c = mode_e'(decim_mode);
    assign lane_c = ant_flag ? iq_t'(adc_data[2*LANE_W-1:LANE_W])
                             : iq_t'(adc_data[LANE_W-1:0]);
    assign avg_c.i = half_sum(held_q.i, lane_c.i);
    assign avg_c.q = half_sum(held_q.q, lane_c.q);

    // A resync pulse or a mode change restarts the pair at this very sample.
    assign resync_c    = phase_resync || (decim_mode != mode_q);
    assign eff_phase_c = resync_c ? PH_FIRST : phase_q;

    always_comb begin
        phase_n    = phase_q;
        held_n     = held_q;
        fwd_c      = 1'b0;
        fwd_data_c = lane_c;
        if (adc_valid) begin
            phase_n = (eff_phase_c == PH_FIRST) ? PH_SECOND : PH_FIRST;
            if (eff_phase_c == PH_FIRST) begin
                held_n = lane_c;
            end
            case (mode_c)
                MODE_EVEN: fwd_c = (eff_phase_c == PH_FIRST);
                MODE_ODD:  fwd_c = (eff_phase_c == PH_SECOND);
                MODE_AVG: begin
                    fwd_c      = (eff_phase_c == PH_SECOND);
                    fwd_data_c = avg_c;
                end
                default:   fwd_c = 1'b1;
            endcase
        end else if (resync_c) begin
            phase_n = PH_FIRST;
            held_n  = '0;
        end
    end

    always_ff @(posedge acc_clk or negedge acc_rstn) begin
        if (!acc_rstn) begin
            phase_q      <= PH_FIRST;
            held_q       <= '0;
            mode_q       <= '0;
            stage_vld_q  <= 1'b0;
            stage_data_q <= '0;
        end else begin
            phase_q      <= phase_n;
            held_q       <= held_n;
            mode_q       <= decim_mode;
            stage_vld_q  <= fwd_c;
            stage_data_q <= fwd_c ? fwd_data_c : stage_data_q;
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead FIFO with a registered head word
    // ------------------------------------------------------------------
    logic [LANE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_q;
    logic [PTR_W-1:0]  wr_q;
    logic [PTR_W-1:0]  rd_n;
    logic [LVL_W-1:0]  level_q;
    logic [LVL_W-1:0]  level_n;
    logic [LANE_W-1:0] head_q;
    logic [LANE_W-1:0] head_n;
    logic              valid_q;
    logic              ovf_q;
    logic              ovf_n;
    logic              full_c;
    logic              pop_c;
    logic              wr_c;
    logic              drop_c;

    assign full_c = (level_q == LVL_W'(DEPTH));
    assign pop_c  = valid_q && data_ready_from_acc;
    assign wr_c   = stage_vld_q && (!full_c || pop_c);
    assign drop_c = stage_vld_q && full_c && !pop_c;

    always_comb begin
        level_n = level_q;
        rd_n    = rd_q;
        head_n  = '0;
        ovf_n   = ovf_q;
        if (wr_c && !pop_c) begin
            level_n = level_q + LVL_W'(1);
        end else if (!wr_c && pop_c) begin
            level_n = level_q - LVL_W'(1);
        end
        if (pop_c) begin
            rd_n = rd_q + PTR_W'(1);
        end
        // The word landing at the new read slot this edge is not in mem yet.
        if (level_n != '0) begin
            if (wr_c && (wr_q == rd_n)) begin
                head_n = stage_data_q;
            end else begin
                head_n = mem[rd_n];
            end
        end
        if (drop_c) begin
            ovf_n = 1'b1;
        end else if (clr_overflow) begin
            ovf_n = 1'b0;
        end
    end

    always_ff @(posedge acc_clk) begin
        if (wr_c) begin
            mem[wr_q] <= stage_data_q;
        end
    end

    always_ff @(posedge acc_clk or negedge acc_rstn) begin
        if (!acc_rstn) begin
            rd_q    <= '0;
            wr_q    <= '0;
            level_q <= '0;
            head_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            rd_q    <= rd_n;
            wr_q    <= wr_c ? wr_q + PTR_W'(1) : wr_q;
            level_q <= level_n;
            head_q  <= head_n;
            valid_q <= (level_n != '0);
            ovf_q   <= ovf_n;
        end
    end

    assign data_to_acc       = head_q;
    assign data_valid_to_acc = valid_q;
    assign fifo_level        = level_q;
    assign overflow_sticky   = ovf_q;

endmodule

// File: tb/tb_adc_decim_intf.sv
// Bench for adc_decim_intf: directed vector table, hand sequences and a queue-based reference model.
module tb_adc_decim_intf;

    localparam int unsigned DEPTH = 16;

    logic        acc_clk = 1'b0;
    logic        acc_rstn = 1'b1;
    logic [63:0] adc_data = '0;
    logic        adc_valid = 1'b0;
    logic        ant_flag = 1'b0;
    logic [1:0]  decim_mode = '0;
    logic        phase_resync = 1'b0;
    logic [31:0] data_to_acc;
    logic        data_valid_to_acc;
    logic        data_ready_from_acc = 1'b0;
    logic [4:0]  fifo_level;
    logic        overflow_sticky;
    logic        clr_overflow = 1'b0;

    adc_decim_intf dut (
        .acc_clk             (acc_clk),
        .acc_rstn            (acc_rstn),
        .adc_data            (adc_data),
        .adc_valid           (adc_valid),
        .ant_flag            (ant_flag),
        .decim_mode          (decim_mode),
        .phase_resync        (phase_resync),
        .data_to_acc         (data_to_acc),
        .data_valid_to_acc   (data_valid_to_acc),
        .data_ready_from_acc (data_ready_from_acc),
        .fifo_level          (fifo_level),
        .overflow_sticky     (overflow_sticky),
        .clr_overflow        (clr_overflow)
    );

    always #5 acc_clk = ~acc_clk;

    int errs = 0;
    int checks = 0;

    // Reference model state: pair phase, held sample, pipeline stage and FIFO queue.
    bit          m_phase;
    logic [31:0] m_held;
    logic [1:0]  m_mode_prev;
    bit          m_stg_v;
    logic [31:0] m_stg_d;
    logic [31:0] m_q[$];
    bit          m_ovf;
    logic [31:0] got[$];

    typedef struct {
        logic [1:0]  mode;
        bit          ant;
        logic [63:0] s0;
        logic [63:0] s1;
        int          lvl;
        logic [31:0] head;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] iq(input int i, input int q);
        return {16'(i), 16'(q)};
    endfunction

    function automatic logic [63:0] w(input logic [31:0] l1, input logic [31:0] l0);
        return {l1, l0};
    endfunction

    function automatic int floor_half(input int s);
        return (s >= 0) ? s / 2 : -((1 - s) / 2);
    endfunction

    function automatic logic [31:0] avg_m(input logic [31:0] x, input logic [31:0] y);
        logic signed [15:0] xi, xq, yi, yq;
        xi = x[31:16]; xq = x[15:0]; yi = y[31:16]; yq = y[15:0];
        return iq(floor_half(int'(xi) + int'(yi)), floor_half(int'(xq) + int'(yq)));
    endfunction

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic cycle(input bit v, input logic [63:0] d, input bit ant, input logic [1:0] mode,
                         input bit rs, input bit rdy, input bit clr);
        bit          pop, drop, resync, ph, fwd;
        logic [31:0] lane, fd;
        adc_valid = v; adc_data = d; ant_flag = ant; decim_mode = mode;
        phase_resync = rs; data_ready_from_acc = rdy; clr_overflow = clr;
        if (rdy && data_valid_to_acc) got.push_back(data_to_acc);

        pop = rdy && (m_q.size() > 0);
        if (pop) void'(m_q.pop_front());
        drop = 1'b0;
        if (m_stg_v) begin
            if (m_q.size() < DEPTH) m_q.push_back(m_stg_d);
            else drop = 1'b1;
        end
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;

        resync = rs || (mode != m_mode_prev);
        ph     = resync ? 1'b0 : m_phase;
        lane   = ant ? d[63:32] : d[31:0];
        fwd    = 1'b0;
        fd     = lane;
        if (v) begin
            case (mode)
                2'd0: fwd = !ph;
                2'd1: fwd = ph;
                2'd2: begin fwd = ph; fd = avg_m(m_held, lane); end
                default: fwd = 1'b1;
            endcase
            if (!ph) m_held = lane;
            m_phase = !ph;
        end else if (resync) begin
            m_phase = 1'b0;
            m_held  = '0;
        end
        m_stg_v = fwd;
        m_stg_d = fd;
        m_mode_prev = mode;

        @(posedge acc_clk);
        #1;
        chk("level", 64'(fifo_level), 64'(m_q.size()));
        chk("valid", 64'(data_valid_to_acc), 64'(m_q.size() != 0));
        chk("overflow", 64'(overflow_sticky), 64'(m_ovf));
        if (m_q.size() > 0) chk("head", 64'(data_to_acc), 64'(m_q[0]));
    endtask

    task automatic idle(input int n, input logic [1:0] mode, input bit rdy);
        for (int k = 0; k < n; k++) cycle(1'b0, '0, 1'b0, mode, 1'b0, rdy, 1'b0);
    endtask

    // Asynchronous reset away from any clock edge; outputs must clear at once.
    task automatic do_reset(input logic [1:0] mode);
        adc_valid = 1'b0; adc_data = '0; ant_flag = 1'b0; decim_mode = mode;
        phase_resync = 1'b0; data_ready_from_acc = 1'b0; clr_overflow = 1'b0;
        #2 acc_rstn = 1'b0;
        #1;
        chk("rst_data", 64'(data_to_acc), 64'd0);
        chk("rst_valid", 64'(data_valid_to_acc), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_ovf", 64'(overflow_sticky), 64'd0);
        @(posedge acc_clk);
        @(posedge acc_clk);
        @(negedge acc_clk);
        acc_rstn = 1'b1;
        @(posedge acc_clk);
        #1;
        m_phase = 1'b0; m_held = '0; m_mode_prev = mode; m_stg_v = 1'b0; m_stg_d = '0;
        m_q.delete(); m_ovf = 1'b0; got.delete();
    endtask

    task automatic chk_got(input string name, input logic [31:0] exp[$]);
        chk({name, "_count"}, 64'(got.size()), 64'(exp.size()));
        for (int j = 0; j < exp.size() && j < got.size(); j++) chk(name, 64'(got[j]), 64'(exp[j]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp[$];
        logic [1:0]  cur_mode;
        int          rate;

        vt[0] = '{2'd0, 1'b0, w(iq(7, 7), iq(10, 20)), w(iq(8, 8), iq(30, 40)), 1, iq(10, 20)};
        vt[1] = '{2'd1, 1'b0, w(iq(7, 7), iq(10, 20)), w(iq(8, 8), iq(30, 40)), 1, iq(30, 40)};
        vt[2] = '{2'd2, 1'b1, w(iq(3, -3), iq(99, 99)), w(iq(4, -6), iq(-5, 5)), 1, iq(3, -5)};
        vt[3] = '{2'd2, 1'b1, w(iq(-32768, -1), iq(1, 1)), w(iq(-32767, -1), iq(2, 2)), 1, iq(-32768, -1)};
        vt[4] = '{2'd3, 1'b1, w(iq(11, 12), '0), w(iq(13, 14), '0), 2, iq(11, 12)};
        vt[5] = '{2'd2, 1'b0, w('0, iq(32767, 32767)), w('0, iq(32767, 32767)), 1, iq(32767, 32767)};
        vt[6] = '{2'd2, 1'b0, w('0, iq(-1, 1)), w('0, iq(0, 0)), 1, iq(-1, 0)};

        @(posedge acc_clk);
        #1;

        // Vector table: one sample pair per record, FIFO not drained.
        for (int i = 0; i < 7; i++) begin
            do_reset(vt[i].mode);
            cycle(1'b1, vt[i].s0, vt[i].ant, vt[i].mode, 1'b0, 1'b0, 1'b0);
            cycle(1'b1, vt[i].s1, vt[i].ant, vt[i].mode, 1'b0, 1'b0, 1'b0);
            idle(2, vt[i].mode, 1'b0);
            chk("vec_level", 64'(fifo_level), 64'(vt[i].lvl));
            chk("vec_head", 64'(data_to_acc), 64'(vt[i].head));
        end

        // Keep-even with a ready consumer; output valid two edges after sample 0.
        do_reset(2'd0);
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, w(iq(k + 500, 0), iq(k, 100 + k)), 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
            if (k == 0) chk("latency_e0", 64'(data_valid_to_acc), 64'd0);
            if (k == 1) chk("latency_e1", 64'(data_valid_to_acc), 64'd1);
        end
        idle(4, 2'd0, 1'b1);
        exp = '{iq(0, 100), iq(2, 102), iq(4, 104), iq(6, 106)};
        chk_got("even_out", exp);

        // Bypass into a stalled consumer: fill, overflow, then pop with clear.
        do_reset(2'd3);
        for (int k = 0; k < 20; k++) cycle(1'b1, w('0, iq(k, k + 50)), 1'b0, 2'd3, 1'b0, 1'b0, 1'b0);
        idle(2, 2'd3, 1'b0);
        chk("ovf_level", 64'(fifo_level), 64'd16);
        chk("ovf_set", 64'(overflow_sticky), 64'd1);
        chk("ovf_head", 64'(data_to_acc), 64'(iq(0, 50)));
        cycle(1'b0, '0, 1'b0, 2'd3, 1'b0, 1'b1, 1'b1);
        chk("clr_head", 64'(data_to_acc), 64'(iq(1, 51)));
        chk("clr_ovf", 64'(overflow_sticky), 64'd0);
        chk("clr_level", 64'(fifo_level), 64'd15);

        // Full FIFO with a pending write and a pop on the same edge.
        do_reset(2'd3);
        for (int k = 0; k < 17; k++) cycle(1'b1, w('0, iq(k, k)), 1'b0, 2'd3, 1'b0, 1'b0, 1'b0);
        chk("full_level", 64'(fifo_level), 64'd16);
        cycle(1'b0, '0, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0);
        chk("popwr_level", 64'(fifo_level), 64'd16);
        chk("popwr_ovf", 64'(overflow_sticky), 64'd0);
        got.delete();
        idle(17, 2'd3, 1'b1);
        exp.delete();
        for (int k = 1; k <= 16; k++) exp.push_back(iq(k, k));
        chk_got("drain", exp);

        // Keep-odd with a resync on sample 5.
        do_reset(2'd1);
        for (int k = 0; k < 12; k++)
            cycle(1'b1, w('0, iq(k, 0)), 1'b0, 2'd1, (k == 5), 1'b1, 1'b0);
        idle(4, 2'd1, 1'b1);
        exp = '{iq(1, 0), iq(3, 0), iq(6, 0), iq(8, 0), iq(10, 0)};
        chk_got("resync_out", exp);

        // Average, switch to keep-even after a held sample, then reset mid-stream.
        do_reset(2'd2);
        cycle(1'b1, w('0, iq(50, 51)), 1'b0, 2'd2, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, w('0, iq(60, 61)), 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, w('0, iq(70, 71)), 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        idle(3, 2'd0, 1'b1);
        exp = '{iq(60, 61)};
        chk_got("modechg_out", exp);
        cycle(1'b1, w('0, iq(1000, 1000)), 1'b0, 2'd2, 1'b0, 1'b1, 1'b0);
        do_reset(2'd2);
        cycle(1'b1, w('0, iq(10, 10)), 1'b0, 2'd2, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, w('0, iq(20, 20)), 1'b0, 2'd2, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, w('0, iq(30, 31)), 1'b0, 2'd2, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, w('0, iq(40, 41)), 1'b0, 2'd2, 1'b0, 1'b1, 1'b0);
        idle(4, 2'd2, 1'b1);
        exp = '{iq(15, 15), iq(35, 36)};
        chk_got("postrst_out", exp);

        // Randomized traffic against the model, alternating consumer speed.
        do_reset(2'd0);
        cur_mode = 2'd0;
        for (int n = 0; n < 800; n++) begin
            if ($urandom % 20 == 0) cur_mode = 2'($urandom % 4);
            rate = ((n / 100) % 2 == 1) ? 20 : 80;
            cycle(($urandom % 10) < 7, {$urandom, $urandom}, 1'($urandom % 2), cur_mode,
                  ($urandom % 25) == 0, int'($urandom % 100) < rate, ($urandom % 16) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/adc_decim_intf.md
Name: adc_decim_intf

Overview:
- RX-side counterpart of the TX DAC interface, in the acc_clk domain after the ADC CDC.
- Takes the 40 Msps two-antenna packed ADC stream and selects one antenna.
- Decimates 2:1 to 20 Msps by drop-even, drop-odd or pair-average.
- Buffers samples in a small synchronous FWFT FIFO, delivered to the RX baseband with a valid/ready handshake and sticky overflow reporting.

Parameters:
- IQ_DATA_WIDTH, 16: width of each I and each Q component.
- ADC_PACK_DATA_WIDTH, 64: packed ADC word width, two antennas × (I,Q).
- FIFO_DEPTH_LOG2, 4: log2 of output FIFO depth (16 entries).

Ports:
- acc_clk  in  1  block clock.
- acc_rstn  in  1  reset; asynchronous, active-low.
- adc_data  in  ADC_PACK_DATA_WIDTH  [63:32] = ant1 {I,Q}, [31:0] = ant0 {I,Q}; I in the upper half of each 32-bit lane.
- adc_valid  in  1  adc_data is a new 40 Msps sample this cycle.
- ant_flag  in  1  0 = ant0 lane, 1 = ant1 lane.
- decim_mode  in  2  0 = keep even, 1 = keep odd, 2 = average pair, 3 = bypass (no decimation).
- phase_resync  in  1  one-cycle pulse; restarts pair phase.
- data_to_acc  out  2*IQ_DATA_WIDTH  FIFO head sample, {I,Q}.
- data_valid_to_acc  out  1  FIFO not empty.
- data_ready_from_acc  in  1  consumer pops head when valid and ready are both high.
- fifo_level  out  FIFO_DEPTH_LOG2+1  current occupancy, 0..16.
- overflow_sticky  out  1  a decimated sample was dropped because the FIFO was full.
- clr_overflow  in  1  clears overflow_sticky.

Behaviour:
Reset (acc_rstn low, asynchronous):
- Phase = 0, held sample cleared, stage register invalid, FIFO empty.
- All outputs 0: data_to_acc, data_valid_to_acc, fifo_level, overflow_sticky.

Lane select:
- Lane = ant_flag ? adc_data[63:32] : adc_data[31:0].
- Evaluated on every valid input cycle.

Phase:
- 1-bit phase toggles on each adc_valid.
- Phase 0 = first sample of pair, phase 1 = second.

Modes:
- Mode 0: phase-0 sample forwarded, phase-1 sample discarded.
- Mode 1: phase-1 sample forwarded.
- Mode 2: phase-0 sample held; on phase 1 output I = (Ih+Ic)>>>1 and Q likewise.
  - Sign-extend to IQ_DATA_WIDTH+1, add, arithmetic shift right 1, keep low IQ_DATA_WIDTH bits.
  - Rounds toward -inf; no overflow is possible.
- Mode 3: every valid sample forwarded; phase still toggles.

Pipeline:
- Forwarded result is registered into the stage at the accepting edge E0.
- Written into the FIFO at E1.
- data_valid_to_acc is high after E1 if the FIFO was empty: 2-edge latency from input to output.

Resync and mode change:
- phase_resync, or any change of decim_mode seen in the registered copy, forces phase = 0 and discards the held sample.
- If adc_valid is high in the same cycle, that sample is treated as phase 0.

FIFO:
- Show-ahead; data_to_acc is always the head entry.
- Pop when valid && ready. Pop with FIFO empty: ignored, no state change.
- Write when stage valid and (not full or pop this cycle).
- Simultaneous pop and write at full: both occur, level stays 16, no overflow.

Overflow:
- Stage valid, full, no pop: the new word is dropped, old contents kept, overflow_sticky <= 1.
- clr_overflow clears the sticky; a set condition in the same cycle wins.

Other:
- fifo_level is registered and updates on the edge after a write/pop.
- Pointers wrap modulo 16; full = level 16, empty = level 0.
- adc_valid low: no state change except FIFO pops.

Test Plan:
- Reset, mode 0, ant_flag = 0, feed ant0 I = 0..7, Q = 100..107 on consecutive valids, ready = 1 -> outputs I = 0,2,4,6 with Q = 100,102,104,106. First valid_to_acc 2 edges after sample 0.
- Mode 2, ant_flag = 1, ant1 pairs (I,Q) = (3,−3),(4,−6) then (−32768,−1),(−32767,−1) -> outputs (3,−5) and (−32768,−1). Confirms floor rounding and the sign-extension range.
- Mode 3, ready = 0, feed 20 samples -> fifo_level = 16, overflow_sticky = 1, head = sample 0. Assert ready for one cycle together with clr_overflow -> head = sample 1, sticky = 0.
- FIFO full with a write pending and pop in the same cycle -> level stays 16, sticky stays 0, new sample is at the tail (verify by draining all 16).
- Mode 1; pulse phase_resync coincident with sample 5 of stream 0..11 -> outputs 1,3, then 6,8,10 (sample 5 is treated as phase 0).
- Mode 2; switch mode 2 -> 0 after one phase-0 sample, then drop acc_rstn asynchronously mid-stream -> held sample discarded. All outputs read 0 immediately without a clock edge; restart yields phase-0 alignment from the first post-reset valid.
